// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for one external memory lane
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to enable the BUSY timeout (TIMEOUT_CYCLES).
module mem_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 6
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_oe,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [SIZE_W-1:0] r0_size,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rdy,
    input  logic              r1_oe,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [SIZE_W-1:0] r1_size,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rdy,
    output logic              m_oe,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [SIZE_W-1:0] m_size,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rdy,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              err_conflict,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;

    logic        valid0;
    logic        valid1;
    logic        conflict0;
    logic        conflict1;
    logic        pick1;
    logic        wd_expire;
    logic [DATA_W-1:0] resp_data;

    assign valid0    = r0_oe ^ r0_we;
    assign valid1    = r1_oe ^ r1_we;
    assign conflict0 = r0_oe & r0_we;
    assign conflict1 = r1_oe & r1_we;

    // r1 wins when alone, or on a tie when r0 was the previous owner
    assign pick1 = valid1 & (~valid0 | ~last_grant);

    // Writes return zero; a watchdog completion (no m_rdy) also returns zero
    assign resp_data = (m_rdy && m_oe) ? m_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    assign wd_expire = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant        <= 2'b00;
            busy         <= 1'b0;
            err_conflict <= 1'b0;
            m_oe         <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_size       <= '0;
            r0_rdy       <= 1'b0;
            r1_rdy       <= 1'b0;
            r0_rdata     <= '0;
            r1_rdata     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_cnt       <= 16'd0;
            err_timeout  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (conflict0 || conflict1) begin
                        err_conflict <= 1'b1;
                    end
                    if (valid0 || valid1) begin
                        state      <= BUSY;
                        busy       <= 1'b1;
                        grant      <= pick1 ? 2'b10 : 2'b01;
                        last_grant <= pick1;
                        m_oe       <= pick1 ? r1_oe    : r0_oe;
                        m_we       <= pick1 ? r1_we    : r0_we;
                        m_addr     <= pick1 ? r1_addr  : r0_addr;
                        m_wdata    <= pick1 ? r1_wdata : r0_wdata;
                        m_size     <= pick1 ? r1_size  : r0_size;
`ifdef MEM_ARB_TIMEOUT_EN
                        wd_cnt     <= 16'd0;
`endif
                    end
                end

                BUSY: begin
                    if (m_rdy || wd_expire) begin
                        state   <= RESP;
                        m_oe    <= 1'b0;
                        m_we    <= 1'b0;
                        m_addr  <= '0;
                        m_wdata <= '0;
                        m_size  <= '0;
                        if (grant[0]) begin
                            r0_rdy   <= 1'b1;
                            r0_rdata <= resp_data;
                        end
                        if (grant[1]) begin
                            r1_rdy   <= 1'b1;
                            r1_rdata <= resp_data;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        if (!m_rdy) begin
                            err_timeout <= 1'b1;
                        end
`endif
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    wd_cnt <= wd_cnt + 16'd1;
`endif
                end

                RESP: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    grant    <= 2'b00;
                    r0_rdy   <= 1'b0;
                    r1_rdy   <= 1'b0;
                    r0_rdata <= '0;
                    r1_rdata <= '0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter sharing one off-chip memory port (oe/we/addr/wdata/size request, DataRdy response, per-lane protocol of the HLS `main` top-level) between two HLS accelerator masters. Sits between the accelerators' `Mout_*` buses and one lane of the external memory interface. It serialises transactions, holds one grant until the memory signals ready, and routes read data and ready back to the owner. Both requesters see the same handshake they would see from memory.

## Interface
- `ADDR_W`, 11, address width of one lane.
- `DATA_W`, 32, data width of one lane.
- `SIZE_W`, 6, width of the access-size field (bits transferred).
- `TIMEOUT_CYCLES`, 1024, watchdog limit; used only with `MEM_ARB_TIMEOUT_EN`.

- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-low.
- `r0_oe`, `r1_oe` in 1 — read request.
- `r0_we`, `r1_we` in 1 — write request.
- `r0_addr`, `r1_addr` in ADDR_W — byte address.
- `r0_wdata`, `r1_wdata` in DATA_W — write data.
- `r0_size`, `r1_size` in SIZE_W — access size in bits.
- `r0_rdata`, `r1_rdata` out DATA_W — read data, valid with rdy.
- `r0_rdy`, `r1_rdy` out 1 — one-cycle completion pulse.
- `m_oe`, `m_we` out 1 — memory read/write enable.
- `m_addr` out ADDR_W, `m_wdata` out DATA_W, `m_size` out SIZE_W — memory request fields.
- `m_rdata` in DATA_W, `m_rdy` in 1 — memory response.
- `grant` out 2 — one-hot owner, 0 when idle.
- `busy` out 1 — state ≠ IDLE.
- `err_conflict` out 1 — sticky: a requester drove oe and we together.
- `err_timeout` out 1 — sticky watchdog error. Tied 0 without the macro.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- **IDLE:** a requester is valid when oe XOR we = 1. If it drives oe and we together, set `err_conflict` and do not grant it.
  - One valid requester: it wins.
  - Two valid requesters: the one not in `last_grant` wins.
  - At the clock edge, capture the winner's oe, we, addr, wdata and size into holding registers. Set `grant`, update `last_grant` and go to BUSY.
- **BUSY:** drive `m_*` from the holding registers; requester inputs are ignored. When `m_rdy`=1, capture `m_rdata`, deassert `m_oe`/`m_we` and go to RESP.
- **RESP:** pulse the owner's `rN_rdy` for one cycle with `rN_rdata` = captured data. Captured data is 0 for writes. Clear `grant` and go to IDLE.
- Requester rule: hold the request stable until `rN_rdy` is seen. Deassert it in the cycle after `rdy`, or present the next request then.
- Non-owner `rN_rdata` = 0 and `rN_rdy` = 0.
- `m_addr`, `m_wdata` and `m_size` are 0 whenever `m_oe`=`m_we`=0.
- Reset values: every output 0 and state IDLE. `last_grant` resets to 1, so r0 wins the first tie.
- Reset asserted mid-transaction: the in-flight access is dropped, no rdy is pulsed, `m_oe`/`m_we` fall immediately, and sticky errors clear.
- Sticky errors clear only on reset.

## Timing
- Request seen in IDLE at cycle 0 → `m_oe`/`m_we` high from cycle 1.
- `m_rdy` high at cycle k (k≥1) → `rN_rdy` high at cycle k+1, and `m_oe`/`m_we` low from k+1.
- Back-to-back: the next grant is captured at the end of the first IDLE cycle after RESP. That gives a 3-cycle overhead per access on top of memory latency; with memory read delay 2, a read completes in 4 cycles.
- `m_rdy` is ignored in IDLE and RESP.
- `m_rdy` in the same cycle the watchdog expires counts as completion; the timeout is not taken.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUSY and counts each BUSY cycle.
  - If it reaches `TIMEOUT_CYCLES` without `m_rdy`: deassert `m_*`, set `err_timeout`, go to RESP with `rN_rdata`=0. The requester still gets its `rdy` pulse.
- Undefined: no counter; BUSY waits indefinitely; `err_timeout` = 0.

## Test plan
- Single read: r0_oe=1, addr=0x010, size=32, memory returns 0xDEADBEEF with `m_rdy` 2 cycles after `m_oe` → `m_oe` rises at cycle 1; `r0_rdy` pulses once with `r0_rdata`=0xDEADBEEF at cycle 4; `grant` returns to 0.
- Simultaneous requests: r0 and r1 write continuously, 3 accesses each → grants alternate r0,r1,r0,r1,r0,r1; each `rN_rdy` pulse is exactly one cycle; `m_wdata` matches the owner's data.
- Conflict: r1_oe=r1_we=1 while r0_oe=1 → `err_conflict`=1 next cycle; only r0 is granted; r1 never sees rdy.
- Reset mid-BUSY: drop `reset` while `m_oe`=1 → `m_oe`, `grant`, `busy` and errors are 0 asynchronously; after release, r0 wins the first tie.
- Timeout (macro defined, TIMEOUT_CYCLES=8): `m_rdy` held 0 → `err_timeout`=1 after 8 BUSY cycles and `r0_rdy` pulses with `r0_rdata`=0. Without the macro, BUSY persists for 100 cycles and `err_timeout`=0.
